// File: rtl/leds_racer_core_n.sv
// Racer game core for 1..8 players: menu/countdown/game/end screens, winner latch, registered LED mixer.
// Optional macro FALSE_START_EN: a press during the countdown disqualifies that player.
module leds_racer_core_n #(
    parameter int NUM_PLAYERS              = 4,
    parameter int MAX_POS                  = 16,
    parameter int MENU_TIMER_CLK_COUNT     = 50000000,
    parameter int COUNTDOWN_STEP_CLK_COUNT = 50000000,
    parameter int END_TIMER_CLK_COUNT      = 750000000,
    localparam int PW = $clog2(MAX_POS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_PLAYERS-1:0] players_commands,
    input  logic [PW-1:0]          current_led,
    output logic [7:0]             led_red_intensity,
    output logic [7:0]             led_green_intensity,
    output logic [7:0]             led_blue_intensity,
    output logic                   update_frame,
    output logic [1:0]             current_screen,
    output logic [NUM_PLAYERS-1:0] ready_mask,
    output logic [2:0]             winner,
    output logic                   winner_valid
);

    localparam int MAX_A   = (MENU_TIMER_CLK_COUNT > COUNTDOWN_STEP_CLK_COUNT) ?
                             MENU_TIMER_CLK_COUNT : COUNTDOWN_STEP_CLK_COUNT;
    localparam int MAX_CNT = (MAX_A > END_TIMER_CLK_COUNT) ? MAX_A : END_TIMER_CLK_COUNT;
    localparam int TW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [PW-1:0] POS_LAST  = PW'(MAX_POS - 1);
    localparam logic [TW-1:0] MENU_LAST = TW'(MENU_TIMER_CLK_COUNT - 1);
    localparam logic [TW-1:0] STEP_LAST = TW'(COUNTDOWN_STEP_CLK_COUNT - 1);
    localparam logic [TW-1:0] END_LAST  = TW'(END_TIMER_CLK_COUNT - 1);

    typedef enum logic [1:0] {
        S_MENU      = 2'd0,
        S_COUNTDOWN = 2'd1,
        S_GAME      = 2'd2,
        S_END       = 2'd3
    } screen_t;

    screen_t                screen_q, screen_d;
    logic [NUM_PLAYERS-1:0] ready_q, ready_d;
    logic [NUM_PLAYERS-1:0] prev_q;
    logic [PW-1:0]          pos_q [NUM_PLAYERS];
    logic [PW-1:0]          pos_d [NUM_PLAYERS];
    logic [1:0]             cd_q, cd_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [2:0]             winner_q, winner_d;
    logic                   wv_q, wv_d;
    logic                   uf_q;
    logic                   changed;
    logic                   found;
    logic [NUM_PLAYERS-1:0] press;
    logic [23:0]            mix_q, mix_d;
    logic [23:0]            pal;
    logic [10:0]            sum_r, sum_g, sum_b;
    int                     led_int;

    function automatic logic [23:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    palette = 24'h400000;
            3'd1:    palette = 24'h000040;
            3'd2:    palette = 24'h004000;
            3'd3:    palette = 24'h404000;
            3'd4:    palette = 24'h004040;
            3'd5:    palette = 24'h400040;
            3'd6:    palette = 24'h202020;
            default: palette = 24'h401600;
        endcase
    endfunction

    function automatic logic [7:0] sat8(input logic [10:0] v);
        sat8 = (v > 11'd255) ? 8'hFF : v[7:0];
    endfunction

    assign press = players_commands & ~prev_q;

    always_comb begin
        screen_d = screen_q;
        ready_d  = ready_q;
        pos_d    = pos_q;
        cd_d     = cd_q;
        timer_d  = timer_q;
        winner_d = winner_q;
        wv_d     = wv_q;
        found    = 1'b0;
        changed  = 1'b0;
        case (screen_q)
            S_MENU: begin
                ready_d = ready_q | press;
                if (press != '0) begin
                    timer_d = '0;
                end else if (ready_q != '0) begin
                    if (timer_q == MENU_LAST) begin
                        screen_d = S_COUNTDOWN;
                        cd_d     = 2'd3;
                        timer_d  = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            S_COUNTDOWN: begin
`ifdef FALSE_START_EN
                ready_d = ready_q & ~press;
`endif
                if (timer_q == STEP_LAST) begin
                    timer_d = '0;
                    if (cd_q == 2'd1) begin
                        screen_d = S_GAME;
                        cd_d     = 2'd0;
                    end else begin
                        cd_d = cd_q - 2'd1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_GAME: begin
                for (int i = 0; i < NUM_PLAYERS; i++) begin
                    if (press[i] && ready_q[i] && pos_q[i] != POS_LAST)
                        pos_d[i] = pos_q[i] + 1'b1;
                end
                // Ascending scan so the lowest finishing index takes the win.
                for (int i = 0; i < NUM_PLAYERS; i++) begin
                    if (!found && pos_d[i] == POS_LAST) begin
                        found    = 1'b1;
                        winner_d = 3'(i);
                    end
                end
                if (found) begin
                    screen_d = S_END;
                    wv_d     = 1'b1;
                    timer_d  = '0;
                end
            end
            default: begin
                if (timer_q == END_LAST) begin
                    screen_d = S_MENU;
                    ready_d  = '0;
                    for (int i = 0; i < NUM_PLAYERS; i++) pos_d[i] = '0;
                    winner_d = 3'd0;
                    wv_d     = 1'b0;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
        endcase
        // Everyone disqualified: abandon the round.
        if (screen_q != S_MENU && ready_q == '0) begin
            screen_d = S_MENU;
            cd_d     = 2'd0;
            timer_d  = '0;
        end
        if (screen_d != screen_q || ready_d != ready_q || cd_d != cd_q) changed = 1'b1;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (pos_d[i] != pos_q[i]) changed = 1'b1;
        end
    end

    always_comb begin
        mix_d   = '0;
        pal     = '0;
        sum_r   = '0;
        sum_g   = '0;
        sum_b   = '0;
        led_int = int'(current_led);
        if (led_int < MAX_POS) begin
            case (screen_q)
                S_MENU: begin
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        if (led_int == i && ready_q[i]) mix_d = palette(3'(i));
                    end
                end
                S_COUNTDOWN: begin
                    if (led_int < int'(cd_q)) mix_d = 24'h101010;
                end
                S_GAME: begin
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        if (ready_q[i] && pos_q[i] == current_led) begin
                            pal   = palette(3'(i));
                            sum_r = sum_r + {3'b000, pal[23:16]};
                            sum_g = sum_g + {3'b000, pal[15:8]};
                            sum_b = sum_b + {3'b000, pal[7:0]};
                        end
                    end
                    mix_d = {sat8(sum_r), sat8(sum_g), sat8(sum_b)};
                end
                default: mix_d = palette(winner_q);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            screen_q <= S_MENU;
            ready_q  <= '0;
            prev_q   <= '1;
            for (int i = 0; i < NUM_PLAYERS; i++) pos_q[i] <= '0;
            cd_q     <= 2'd0;
            timer_q  <= '0;
            winner_q <= 3'd0;
            wv_q     <= 1'b0;
            uf_q     <= 1'b0;
            mix_q    <= '0;
        end else begin
            screen_q <= screen_d;
            ready_q  <= ready_d;
            prev_q   <= players_commands;
            pos_q    <= pos_d;
            cd_q     <= cd_d;
            timer_q  <= timer_d;
            winner_q <= winner_d;
            wv_q     <= wv_d;
            uf_q     <= changed;
            mix_q    <= mix_d;
        end
    end

    assign led_red_intensity   = mix_q[23:16];
    assign led_green_intensity = mix_q[15:8];
    assign led_blue_intensity  = mix_q[7:0];
    assign update_frame        = uf_q;
    assign current_screen      = screen_q;
    assign ready_mask          = ready_q;
    assign winner              = winner_q;
    assign winner_valid        = wv_q;

endmodule

// File: tb/tb_leds_racer_core_n.sv
// Self-checking bench for leds_racer_core_n: directed scenarios plus a random phase against a behavioural model.
module tb_leds_racer_core_n;

    localparam int NP     = 4;
    localparam int MP     = 8;
    localparam int MENU_N = 10;
    localparam int STEP_N = 5;
    localparam int END_N  = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] players_commands = 4'b0001;
    logic [7:0] cmd8 = 8'h00;
    logic [2:0] current_led = 3'd0;

    logic [7:0] led_r, led_g, led_b;
    logic       update_frame;
    logic [1:0] current_screen;
    logic [3:0] ready_mask;
    logic [2:0] winner;
    logic       winner_valid;

    logic [7:0] r8, g8, b8;
    logic       uf8;
    logic [1:0] screen8;
    logic [7:0] ready8;
    logic [2:0] winner8;
    logic       wv8;

    int checks = 0;
    int failures = 0;

    logic [23:0] pal_tab [8] = '{24'h400000, 24'h000040, 24'h004000, 24'h404000,
                                 24'h004040, 24'h400040, 24'h202020, 24'h401600};

    // Reference model state, in screen terms.
    int          m_screen, m_cd, m_timer, m_winner, m_wv;
    int          m_pos [NP];
    logic [3:0]  m_ready, m_prev;
    logic        m_uf;
    logic [23:0] e_rgb;

    leds_racer_core_n #(
        .NUM_PLAYERS(NP), .MAX_POS(MP), .MENU_TIMER_CLK_COUNT(MENU_N),
        .COUNTDOWN_STEP_CLK_COUNT(STEP_N), .END_TIMER_CLK_COUNT(END_N)
    ) dut (
        .clk(clk), .reset(reset), .players_commands(players_commands),
        .current_led(current_led), .led_red_intensity(led_r),
        .led_green_intensity(led_g), .led_blue_intensity(led_b),
        .update_frame(update_frame), .current_screen(current_screen),
        .ready_mask(ready_mask), .winner(winner), .winner_valid(winner_valid)
    );

    leds_racer_core_n #(
        .NUM_PLAYERS(8), .MAX_POS(MP), .MENU_TIMER_CLK_COUNT(MENU_N),
        .COUNTDOWN_STEP_CLK_COUNT(STEP_N), .END_TIMER_CLK_COUNT(END_N)
    ) dut8 (
        .clk(clk), .reset(reset), .players_commands(cmd8),
        .current_led(current_led), .led_red_intensity(r8),
        .led_green_intensity(g8), .led_blue_intensity(b8),
        .update_frame(uf8), .current_screen(screen8),
        .ready_mask(ready8), .winner(winner8), .winner_valid(wv8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp_mix(input int led);
        int r, g, b;
        r = 0; g = 0; b = 0;
        case (m_screen)
            0: if (led < NP && m_ready[led]) return pal_tab[led];
            1: if (led < m_cd) return 24'h101010;
            2: begin
                for (int i = 0; i < NP; i++) begin
                    if (m_ready[i] && m_pos[i] == led) begin
                        r += int'(pal_tab[i][23:16]);
                        g += int'(pal_tab[i][15:8]);
                        b += int'(pal_tab[i][7:0]);
                    end
                end
                return {8'((r > 255) ? 255 : r), 8'((g > 255) ? 255 : g), 8'((b > 255) ? 255 : b)};
            end
            default: return pal_tab[m_winner];
        endcase
        return 24'h0;
    endfunction

    task automatic model_reset();
        m_screen = 0; m_ready = 4'h0; m_cd = 0; m_timer = 0;
        m_winner = 0; m_wv = 0; m_uf = 1'b0; m_prev = 4'hF; e_rgb = 24'h0;
        for (int i = 0; i < NP; i++) m_pos[i] = 0;
    endtask

    task automatic model_step(input logic [3:0] cmd);
        logic [3:0] press, o_ready;
        int o_screen, o_cd, w;
        int o_pos [NP];
        press = cmd & ~m_prev;
        m_prev = cmd;
        o_screen = m_screen; o_ready = m_ready; o_cd = m_cd; o_pos = m_pos;
        e_rgb = exp_mix(int'(current_led));
        if (m_screen != 0 && m_ready == 4'h0) begin
            m_screen = 0; m_cd = 0; m_timer = 0;
        end else begin
            case (m_screen)
                0: begin
                    if (press != 4'h0) begin
                        m_ready |= press;
                        m_timer = 0;
                    end else if (m_ready != 4'h0) begin
                        if (m_timer == MENU_N - 1) begin
                            m_screen = 1; m_cd = 3; m_timer = 0;
                        end else m_timer++;
                    end
                end
                1: begin
`ifdef FALSE_START_EN
                    m_ready &= ~press;
`endif
                    if (m_timer == STEP_N - 1) begin
                        m_timer = 0;
                        m_cd--;
                        if (m_cd == 0) m_screen = 2;
                    end else m_timer++;
                end
                2: begin
                    for (int i = 0; i < NP; i++)
                        if (press[i] && m_ready[i] && m_pos[i] < MP - 1) m_pos[i]++;
                    w = -1;
                    for (int i = NP - 1; i >= 0; i--)
                        if (m_pos[i] == MP - 1) w = i;
                    if (w >= 0) begin
                        m_screen = 3; m_winner = w; m_wv = 1; m_timer = 0;
                    end
                end
                default: begin
                    if (m_timer == END_N - 1) begin
                        m_screen = 0; m_ready = 4'h0; m_winner = 0; m_wv = 0; m_timer = 0;
                        for (int i = 0; i < NP; i++) m_pos[i] = 0;
                    end else m_timer++;
                end
            endcase
        end
        m_uf = (m_screen != o_screen) || (m_ready != o_ready) || (m_cd != o_cd);
        for (int i = 0; i < NP; i++) if (m_pos[i] != o_pos[i]) m_uf = 1'b1;
    endtask

    task automatic tick(input logic [3:0] cmd, input logic [7:0] c8);
        @(negedge clk);
        players_commands = cmd;
        cmd8 = c8;
        if (!reset) model_reset();
        else model_step(cmd);
        @(posedge clk);
        #1;
        chk("screen", 32'(current_screen), 32'(m_screen));
        chk("ready_mask", 32'(ready_mask), 32'(m_ready));
        chk("winner", 32'(winner), 32'(m_winner));
        chk("winner_valid", 32'(winner_valid), 32'(m_wv));
        chk("update_frame", 32'(update_frame), 32'(m_uf));
        chk("red", 32'(led_r), 32'(e_rgb[23:16]));
        chk("green", 32'(led_g), 32'(e_rgb[15:8]));
        chk("blue", 32'(led_b), 32'(e_rgb[7:0]));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(4'h0, 8'h00);
    endtask

    task automatic race(input logic [3:0] who, input int n);
        for (int k = 0; k < n; k++) begin
            tick(who, 8'h00);
            if (k < n - 1) tick(4'h0, 8'h00);
        end
    endtask

    initial begin
        logic [3:0] rc;
        model_reset();

        // Reset with player 0 held: no join after release.
        for (int k = 0; k < 3; k++) tick(4'b0001, 8'h00);
        chk("reset_uf", 32'(update_frame), 32'h0);
        chk("reset_red", 32'(led_r), 32'h0);
        reset = 1'b1;
        for (int k = 0; k < 30; k++) tick(4'b0001, 8'h00);
        chk("held_no_join", 32'(ready_mask), 32'h0);
        chk("held_menu", 32'(current_screen), 32'h0);

        // Join 0 and 2, countdown, game.
        tick(4'h0, 8'h00);
        tick(4'b0101, 8'h00);
        chk("join_uf", 32'(update_frame), 32'h1);
        idle(MENU_N);
        chk("to_countdown", 32'(current_screen), 32'h1);
        chk("to_countdown_uf", 32'(update_frame), 32'h1);
        idle(3 * STEP_N);
        chk("to_game", 32'(current_screen), 32'h2);
        chk("to_game_uf", 32'(update_frame), 32'h1);

        // Player 2 runs the track alone.
        race(4'b0100, MP - 1);
        chk("p2_end", 32'(current_screen), 32'h3);
        chk("p2_winner", 32'(winner), 32'h2);
        chk("p2_wvalid", 32'(winner_valid), 32'h1);
        idle(END_N - 1);
        chk("end_hold", 32'(current_screen), 32'h3);
        idle(1);
        chk("end_to_menu", 32'(current_screen), 32'h0);
        chk("end_clear_ready", 32'(ready_mask), 32'h0);

        // Tie at the finish: lowest index wins.
        tick(4'b0101, 8'h00);
        idle(MENU_N + 3 * STEP_N);
        race(4'b0101, MP - 2);
        tick(4'h0, 8'h00);
        tick(4'b0101, 8'h00);
        chk("tie_winner", 32'(winner), 32'h0);
        chk("tie_end", 32'(current_screen), 32'h3);
        idle(END_N);

        // Colour sum on LED 0, and a saturating sum on the 8-player build.
        tick(4'b1001, 8'hA9);
        current_led = 3'd0;
        idle(MENU_N + 3 * STEP_N);
        tick(4'h0, 8'h00);
        chk("sum_red", 32'(led_r), 32'h80);
        chk("sum_green", 32'(led_g), 32'h40);
        chk("sum_blue", 32'(led_b), 32'h00);
        chk("p8_screen", 32'(screen8), 32'h2);
        chk("p8_ready", 32'(ready8), 32'hA9);
        chk("p8_sat_red", 32'(r8), 32'hFF);
        chk("p8_green", 32'(g8), 32'h56);
        chk("p8_blue", 32'(b8), 32'h40);
        race(4'b0001, MP - 1);
        chk("p0_winner", 32'(winner), 32'h0);
        idle(END_N);

        // Sole player presses during the countdown.
        tick(4'b0010, 8'h00);
        idle(MENU_N);
        chk("fs_countdown", 32'(current_screen), 32'h1);
        idle(2);
        tick(4'b0010, 8'h00);
`ifdef FALSE_START_EN
        chk("fs_ready_cleared", 32'(ready_mask), 32'h0);
        chk("fs_uf", 32'(update_frame), 32'h1);
        idle(1);
        chk("fs_back_menu", 32'(current_screen), 32'h0);
`else
        chk("fs_ready_kept", 32'(ready_mask), 32'h2);
        idle(3 * STEP_N - 3);
        chk("fs_reach_game", 32'(current_screen), 32'h2);
`endif

        // Random phase: sparse level changes, random LED probing.
        rc = 4'h0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 7) == 0) rc = 4'($urandom_range(0, 15));
            current_led = 3'($urandom_range(0, 7));
            tick(rc, 8'h00);
        end

        // Reset in the middle of play.
        reset = 1'b0;
        tick(rc, 8'h00);
        chk("midreset_screen", 32'(current_screen), 32'h0);
        chk("midreset_ready", 32'(ready_mask), 32'h0);
        reset = 1'b1;
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
